// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI slave (bit clock = clk) bridging opcode/address/data
// frames onto an internal word-addressed RAM with burst auto-increment.
// Optional feature macro: SPI_RAM_BRIDGE_WRAP_EN
//   defined     -> burst address wraps from MEM_DEPTH-1 to 0
//   not defined -> burst address saturates, later words are dropped / read as ones
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no frame; first SS_n-low edge samples opcode MSB
// S_CMD    | sampling opcode LSB
// S_ADDR   | shifting in ADDR_WIDTH start-address bits
// S_WRITE  | shifting in write words, commit on last bit of each word
// S_TURN   | turnaround cycle, first word fetched from RAM
// S_READ   | shifting out prefetched words, next word fetched at word start
// S_IGNORE | reserved opcode, MISO held low until SS_n rises
module spi_ram_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic err
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t                  CNT_ADDR  = cnt_t'(ADDR_WIDTH - 1);
    localparam cnt_t                  CNT_DATA  = cnt_t'(DATA_WIDTH - 1);
    localparam cnt_t                  CNT_ONE   = cnt_t'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_TURN,
        S_READ,
        S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  op_hi;
    logic                  is_read;
    cnt_t                  cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wshift;
    logic [DATA_WIDTH-1:0] rshift;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  oor;
    logic                  beyond;

    logic                  cnt_tc;
    logic                  addr_last;
    logic                  blocked;
    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] word_in;

    logic                  access;
    logic                  mem_we;
    logic                  fetch;
    logic                  advance;
    logic                  over_hit;
    logic                  start_oor;
    logic                  miso_nxt;

    assign cnt_tc     = (cnt == '0);
    assign addr_last  = (addr == LAST_ADDR);
    assign blocked    = oor | beyond;
    assign addr_shift = ADDR_WIDTH'({addr, MOSI});
    assign word_in    = DATA_WIDTH'({wshift, MOSI});
    assign advance    = access & ~blocked;
    assign over_hit   = access & beyond;
    assign busy       = (state != S_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus per-edge RAM access strobes and MISO source
    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        mem_we    = 1'b0;
        fetch     = 1'b0;
        start_oor = 1'b0;
        miso_nxt  = 1'b0;
        if (SS_n) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_CMD;
                S_CMD:    state_nxt = op_hi ? S_IGNORE : S_ADDR;
                S_ADDR: begin
                    if (cnt_tc) begin
                        state_nxt = is_read ? S_TURN : S_WRITE;
                        start_oor = ({1'b0, addr_shift} >= DEPTH_EXT);
                    end
                end
                S_WRITE: begin
                    access = cnt_tc;
                    mem_we = cnt_tc & ~blocked;
                end
                S_TURN: begin
                    state_nxt = S_READ;
                    access    = 1'b1;
                    fetch     = 1'b1;
                end
                S_READ: begin
                    access   = cnt_tc;
                    fetch    = cnt_tc;
                    miso_nxt = cnt_tc ? rdata[DATA_WIDTH-1] : rshift[DATA_WIDTH-1];
                end
                S_IGNORE: state_nxt = S_IGNORE;
                default:  state_nxt = S_IDLE;
            endcase
        end
        // Reset wins over any access decoded on the same edge
        if (rst) begin
            state_nxt = S_IDLE;
            access    = 1'b0;
            mem_we    = 1'b0;
            fetch     = 1'b0;
            start_oor = 1'b0;
            miso_nxt  = 1'b0;
        end
    end

    // Frame datapath: opcode/address capture, bit counter, shifters, flags
    always_ff @(posedge clk) begin
        if (rst) begin
            MISO    <= 1'b0;
            err     <= 1'b0;
            op_hi   <= 1'b0;
            is_read <= 1'b0;
            cnt     <= '0;
            addr    <= '0;
            wshift  <= '0;
            rshift  <= '0;
            oor     <= 1'b0;
            beyond  <= 1'b0;
        end else begin
            MISO <= miso_nxt;
            if (start_oor || over_hit) err <= 1'b1;
            if (!SS_n) begin
                case (state)
                    S_IDLE: op_hi <= MOSI;
                    S_CMD: begin
                        is_read <= MOSI;
                        cnt     <= CNT_ADDR;
                    end
                    S_ADDR: begin
                        addr <= addr_shift;
                        if (cnt_tc) begin
                            oor    <= start_oor;
                            beyond <= 1'b0;
                            cnt    <= is_read ? '0 : CNT_DATA;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    S_WRITE: begin
                        wshift <= word_in;
                        cnt    <= cnt_tc ? CNT_DATA : cnt - CNT_ONE;
                    end
                    S_READ: begin
                        if (cnt_tc) begin
                            rshift <= rdata << 1;
                            cnt    <= CNT_DATA;
                        end else begin
                            rshift <= rshift << 1;
                            cnt    <= cnt - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
                if (advance) begin
`ifdef SPI_RAM_BRIDGE_WRAP_EN
                    addr <= addr_last ? '0 : addr + ADDR_ONE;
`else
                    if (addr_last) beyond <= 1'b1;
                    else           addr   <= addr + ADDR_ONE;
`endif
                end
            end
        end
    end

    // RAM: synchronous write and registered read; blocked accesses read as all-ones
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= word_in;
        if (fetch)  rdata     <= blocked ? '1 : mem[addr];
    end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed bench for spi_ram_bridge: default instance (8/8/256) and a
// 4-bit-address / 16-bit-data / 12-word instance sharing clk and rst.
module tb_spi_ram_bridge;

    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic mosi;
    logic tgt;

    logic ss0, ss1;
    logic miso0, busy0, err0;
    logic miso1, busy1, err1;
    logic miso_s;

    int checks = 0;
    int errors = 0;

    assign ss0    = tgt ? 1'b1 : ss_n;
    assign ss1    = tgt ? ss_n : 1'b1;
    assign miso_s = tgt ? miso1 : miso0;

    always #5 clk = ~clk;

    spi_ram_bridge u_dut (
        .clk  (clk),
        .rst  (rst),
        .SS_n (ss0),
        .MOSI (mosi),
        .MISO (miso0),
        .busy (busy0),
        .err  (err0)
    );

    spi_ram_bridge #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (16),
        .MEM_DEPTH  (12)
    ) u_par (
        .clk  (clk),
        .rst  (rst),
        .SS_n (ss1),
        .MOSI (mosi),
        .MISO (miso1),
        .busy (busy1),
        .err  (err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ss_n = 1'b0;
            mosi = v[i];
            tick();
        end
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
    endtask

    task automatic write_frame(input logic [31:0] a, input int aw, input logic [31:0] d, input int nbits);
        send_bits(32'h0, 2);
        send_bits(a, aw);
        send_bits(d, nbits);
        end_frame();
    endtask

    task automatic read_frame(input logic [31:0] a, input int aw, input int nbits,
                              output logic turn_bit, output logic [31:0] data);
        send_bits(32'h1, 2);
        send_bits(a, aw);
        ss_n = 1'b0;
        mosi = 1'b0;
        tick();
        turn_bit = miso_s;
        data = '0;
        for (int i = 0; i < nbits; i++) begin
            tick();
            data = {data[30:0], miso_s};
        end
        end_frame();
    endtask

    logic        turn;
    logic [31:0] rd;
    logic        acc;
    logic [23:0] pat;

    initial begin
        rst  = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        tgt  = 1'b0;
        tick();
        tick();
        check("reset_miso", miso0, 0);
        check("reset_busy", busy0, 0);
        check("reset_err",  err0,  0);
        rst = 1'b0;
        tick();

        // write A5,3C at 0x10 then read both back
        send_bits(32'h0, 2);
        send_bits(32'h10, 8);
        check("wr_busy_mid", busy0, 1);
        send_bits(32'hA53C, 16);
        check("wr_err", err0, 0);
        end_frame();
        check("wr_busy_end", busy0, 0);

        read_frame(32'h10, 8, 16, turn, rd);
        check("rd_turn_miso", turn, 0);
        check("rd_burst_data", rd, 32'h0000_A53C);
        check("rd_busy_end", busy0, 0);
        check("rd_miso_end", miso0, 0);

        // abort mid-word leaves previous content
        write_frame(32'h20, 8, 32'h5A, 8);
        send_bits(32'h0, 2);
        send_bits(32'h20, 8);
        send_bits(32'h1F, 5);
        end_frame();
        check("abort_busy", busy0, 0);
        check("abort_err", err0, 0);
        read_frame(32'h20, 8, 8, turn, rd);
        check("abort_readback", rd, 32'h5A);

        // reserved opcode 11 followed by 24 bits
        pat = 24'h10EEEE;
        send_bits(32'h3, 2);
        acc = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            ss_n = 1'b0;
            mosi = pat[i];
            tick();
            acc = acc | miso0;
        end
        check("rsvd_busy", busy0, 1);
        check("rsvd_miso", acc, 0);
        end_frame();
        check("rsvd_busy_end", busy0, 0);
        read_frame(32'h10, 8, 16, turn, rd);
        check("rsvd_mem_kept", rd, 32'h0000_A53C);

        // burst across the top of memory
        write_frame(32'h00, 8, 32'h77, 8);
        send_bits(32'h0, 2);
        send_bits(32'hFF, 8);
        send_bits(32'h11, 8);
        check("bnd_err_w0", err0, 0);
        send_bits(32'h22, 8);
`ifdef SPI_RAM_BRIDGE_WRAP_EN
        check("bnd_err_w1", err0, 0);
`else
        check("bnd_err_w1", err0, 1);
`endif
        end_frame();
        read_frame(32'hFF, 8, 8, turn, rd);
        check("bnd_mem_ff", rd, 32'h11);
        read_frame(32'h00, 8, 8, turn, rd);
`ifdef SPI_RAM_BRIDGE_WRAP_EN
        check("bnd_mem_00", rd, 32'h22);
`else
        check("bnd_mem_00", rd, 32'h77);
`endif

        // reset during bit 3 of the word at 0x11 (0x3C -> bits 0,0,1,1)
        send_bits(32'h1, 2);
        send_bits(32'h11, 8);
        ss_n = 1'b0;
        mosi = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("rstmid_bit2", miso0, 1);
        rst = 1'b1;
        tick();
        check("rstmid_miso", miso0, 0);
        check("rstmid_busy", busy0, 0);
        check("rstmid_err",  err0,  0);
        rst  = 1'b0;
        ss_n = 1'b1;
        tick();
        read_frame(32'h11, 8, 8, turn, rd);
        check("rstmid_next", rd, 32'h3C);

        // parametrised instance: out-of-range start address 13 of 12 words
        tgt = 1'b1;
        write_frame(32'd11, 4, 32'h1234, 16);
        write_frame(32'd0, 4, 32'h0F0F, 16);
        check("par_err_clean", err1, 0);
        send_bits(32'h0, 2);
        send_bits(32'd13, 4);
        check("par_err_set", err1, 1);
        send_bits(32'hBEEF, 16);
        end_frame();
        read_frame(32'd13, 4, 16, turn, rd);
        check("par_oor_read", rd, 32'h0000_FFFF);
        read_frame(32'd11, 4, 16, turn, rd);
        check("par_mem_11", rd, 32'h0000_1234);
        read_frame(32'd0, 4, 16, turn, rd);
        check("par_mem_0", rd, 32'h0000_0F0F);
        check("par_busy_end", busy1, 0);
        tgt = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
